convolution_filter_param: RTL and testbench

CONVOLUTION_FILTER_PARAM -- requirements
Module: convolution_filter_param

---
 rtl/convolution_filter_param.sv | 117 +++++++++++
 tb/tb_convolution_filter_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/convolution_filter_param.sv
// convolution_filter_param: streaming 3x3 valid-region convolution with serially loaded signed taps
module convolution_filter_param #(
  parameter int IM_WIDTH  = 32,
  parameter int IM_HEIGHT = 32,
  parameter int DATA_W    = 8,
  parameter int COEFF_W   = 8,
  parameter int SHIFT     = 0,
  parameter int MODE      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coeff_load,
  input  logic signed [COEFF_W-1:0] coeff_in,
  input  logic                      data_load,
  input  logic [DATA_W-1:0]         data_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      data_write,
  output logic                      coeff_ready,
  output logic                      frame_done
);
  localparam int CW = $clog2(IM_WIDTH);
  localparam int RW = $clog2(IM_HEIGHT);
  localparam int PW = DATA_W + COEFF_W + 1;
  localparam int AW = DATA_W + COEFF_W + 4;
  localparam logic signed [AW-1:0] MAXV = {{(AW-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  typedef enum logic [1:0] {IDLE, COEFF, RUN} state_t;
  state_t state_q, state_d;
  logic signed [COEFF_W-1:0] c_q [9];
  logic signed [COEFF_W-1:0] c_d [9];
  logic [3:0] idx_q, idx_d;
  logic coeff_ready_q, coeff_ready_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DATA_W-1:0] lb0_q [IM_WIDTH];
  logic [DATA_W-1:0] lb1_q [IM_WIDTH];
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic signed [PW-1:0] prod_q [9];
  logic signed [PW-1:0] prod_d [9];
  logic signed [AW-1:0] sum_q, sum_d, shifted, mag;
  logic [DATA_W-1:0] data_o_q, data_o_d;
  logic [2:0] v_q, v_d, l_q, l_d;
  logic data_write_q, data_write_d, frame_done_q, frame_done_d;
  logic accept, last_col, last_row;
  assign accept = state_q == RUN && coeff_ready_q && data_load && !coeff_load;
  assign last_col = col_q == CW'(IM_WIDTH - 1);
  assign last_row = row_q == RW'(IM_HEIGHT - 1);
  always_comb begin
    state_d = coeff_load ? (idx_q == 4'd8 ? RUN : COEFF) : state_q;
    c_d = c_q;
    if (coeff_load) c_d[idx_q] = coeff_in;
    idx_d = (!coeff_load || idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
    coeff_ready_d = coeff_load ? idx_q == 4'd8 : coeff_ready_q;
    col_d = !accept ? col_q : last_col ? '0 : col_q + CW'(1);
    row_d = !(accept && last_col) ? row_q : last_row ? '0 : row_q + RW'(1);
    win_d = win_q;
    if (accept) win_d = '{win_q[1], win_q[2], lb0_q[col_q],
                          win_q[4], win_q[5], lb1_q[col_q],
                          win_q[7], win_q[8], data_i};
  end
  // three-stage arithmetic: products, adder tree, shift/clamp
  always_comb begin
    for (int i = 0; i < 9; i++) prod_d[i] = PW'(c_q[i]) * PW'($signed({1'b0, win_q[i]}));
    sum_d = '0;
    for (int i = 0; i < 9; i++) sum_d = sum_d + AW'(prod_q[i]);
    shifted = sum_q >>> SHIFT;
    mag = (MODE == 1 && shifted[AW-1]) ? -shifted : shifted;
    data_o_d = !v_q[2] ? data_o_q : mag[AW-1] ? '0 : (mag > MAXV) ? '1 : mag[DATA_W-1:0];
    v_d = {v_q[1:0], accept && row_q >= RW'(2) && col_q >= CW'(2)};
    l_d = {l_q[1:0], accept && last_col && last_row};
    data_write_d = v_q[2];
    frame_done_d = l_q[2];
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= data_i;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      c_q <= '{default: '0};
      idx_q <= '0;
      coeff_ready_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
      prod_q <= '{default: '0};
      sum_q <= '0;
      data_o_q <= '0;
      v_q <= '0;
      l_q <= '0;
      data_write_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      idx_q <= idx_d;
      coeff_ready_q <= coeff_ready_d;
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      prod_q <= prod_d;
      sum_q <= sum_d;
      data_o_q <= data_o_d;
      v_q <= v_d;
      l_q <= l_d;
      data_write_q <= data_write_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign data_o = data_o_q;
  assign data_write = data_write_q;
  assign coeff_ready = coeff_ready_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_convolution_filter_param.sv
// tb_convolution_filter_param: four filter configurations on a shared stream, checked against an image-level model
module tb_convolution_filter_param;
  logic clk = 1'b0;
  logic rst, coeff_load, data_load;
  logic signed [7:0] coeff_in;
  logic [7:0] data_i;
  logic [3:0][7:0] dout;
  logic [3:0] dw, crdy, fd;
  int n_chk, n_pass, cyc;
  int mc [4][9];
  int mi [4], mrow [4], mcol [4];
  bit mrdy [4];
  int img [4][8][8];
  int ev [4][1024];
  int ed [4][1024];
  bit el [4][1024];
  int wr [4], kill [4], rd [4], ccnt [4];
  int cap_v [4][1024];
  bit cap_f [4][1024];
  int b [4];
  int ones [9], sobel [9], rc [9], rnd [64];
  always #5 clk = ~clk;
  function automatic int gw(input int g); return g == 3 ? 8 : 4; endfunction
  function automatic int gsh(input int g); return g == 1 ? 3 : 0; endfunction
  function automatic bit gmd(input int g); return g == 2; endfunction
  for (genvar g = 0; g < 4; g++) begin : g_dut
    convolution_filter_param #(
      .IM_WIDTH(g == 3 ? 8 : 4), .IM_HEIGHT(g == 3 ? 8 : 4), .DATA_W(8), .COEFF_W(8),
      .SHIFT(g == 1 ? 3 : 0), .MODE(g == 2 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .coeff_load(coeff_load), .coeff_in(coeff_in),
      .data_load(data_load), .data_i(data_i), .data_o(dout[g]), .data_write(dw[g]),
      .coeff_ready(crdy[g]), .frame_done(fd[g])
    );
  end
  task automatic chk(input string nm, input int g, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0d, expected %0d (cycle %0d)", nm, g, act, exp, cyc);
  endtask
  // model: keeps each configuration's whole image and convolves it directly
  always @(posedge clk) begin
    int s;
    cyc++;
    for (int g = 0; g < 4; g++) begin
      if (!rst) begin
        for (int i = 0; i < 9; i++) mc[g][i] = 0;
        mi[g] = 0; mrdy[g] = 0; mrow[g] = 0; mcol[g] = 0; kill[g] = wr[g];
      end else if (coeff_load) begin
        mc[g][mi[g]] = $signed(coeff_in);
        mrdy[g] = mi[g] == 8;
        mi[g] = mi[g] == 8 ? 0 : mi[g] + 1;
      end else begin
        mi[g] = 0;
        if (mrdy[g] && data_load) begin
          img[g][mrow[g]][mcol[g]] = int'(data_i);
          if (mrow[g] >= 2 && mcol[g] >= 2) begin
            s = 0;
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                s += mc[g][i*3+j] * img[g][mrow[g]-2+i][mcol[g]-2+j];
            s = s >>> gsh(g);
            if (gmd(g) && s < 0) s = -s;
            s = s < 0 ? 0 : s > 255 ? 255 : s;
            ev[g][wr[g]] = s;
            el[g][wr[g]] = mrow[g] == gw(g) - 1 && mcol[g] == gw(g) - 1;
            ed[g][wr[g]] = cyc + 3;
            wr[g]++;
          end
          mcol[g]++;
          if (mcol[g] == gw(g)) begin
            mcol[g] = 0;
            mrow[g] = mrow[g] == gw(g) - 1 ? 0 : mrow[g] + 1;
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rd[g] < kill[g]) rd[g] = kill[g];
      if (dw[g]) begin
        cap_v[g][ccnt[g]] = int'(dout[g]);
        cap_f[g][ccnt[g]] = fd[g];
        ccnt[g]++;
        if (rd[g] < wr[g]) begin
          chk("data_o", g, int'(dout[g]), ev[g][rd[g]]);
          chk("frame_done", g, int'(fd[g]), int'(el[g][rd[g]]));
          chk("latency", g, cyc, ed[g][rd[g]]);
          rd[g]++;
        end else chk("unexpected_write", g, int'(dw[g]), 0);
      end else if (rd[g] < wr[g] && ed[g][rd[g]] <= cyc) begin
        chk("missing_write", g, int'(dw[g]), 1);
        rd[g]++;
      end
    end
  end
  task automatic step(); @(posedge clk); #1; endtask
  task automatic load(input int c [9]);
    for (int i = 0; i < 9; i++) begin coeff_load = 1'b1; coeff_in = 8'(c[i]); step(); end
    coeff_load = 1'b0;
  endtask
  task automatic px(input int v, input int gap);
    data_load = 1'b1; data_i = 8'(v); step(); data_load = 1'b0;
    repeat (gap) step();
  endtask
  task automatic frame4(input int kind, input int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) px(kind == 0 ? k : kind == 1 ? 10 * c : 10 * (3 - c), 0);
  endtask
  task automatic snap(); for (int g = 0; g < 4; g++) b[g] = ccnt[g]; endtask
  task automatic pulse_reset(); rst = 1'b0; step(); rst = 1'b1; endtask
  task automatic expect_run(input string nm, input int g, input int off, input int n, input int val);
    for (int i = off; i < off + n; i++) chk(nm, g, cap_v[g][b[g]+i], val);
  endtask
  task automatic expect_cnt(input string nm, input int g, input int n, input int nfd);
    int f = 0;
    for (int i = b[g]; i < ccnt[g]; i++) f += int'(cap_f[g][i]);
    chk({nm, "_count"}, g, ccnt[g] - b[g], n);
    chk({nm, "_frame_done_count"}, g, f, nfd);
  endtask
  initial begin
    rst = 1'b0; coeff_load = 1'b0; coeff_in = '0; data_load = 1'b0; data_i = '0;
    ones = '{default: 1};
    sobel = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    repeat (3) step();
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("reset_data_o", g, int'(dout[g]), 0);
      chk("reset_data_write", g, int'(dw[g]), 0);
      chk("reset_coeff_ready", g, int'(crdy[g]), 0);
      chk("reset_frame_done", g, int'(fd[g]), 0);
    end
    step(); rst = 1'b1;
    coeff_load = 1'b1; coeff_in = 8'sd1;
    repeat (5) step();
    @(negedge clk); chk("coeff_ready_partial", 0, int'(crdy[0]), 0);
    repeat (4) step();
    coeff_load = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) chk("coeff_ready_full", g, int'(crdy[g]), 1);
    snap(); frame4(0, 10); repeat (6) step();
    expect_cnt("const10", 0, 4, 1);
    expect_run("const10", 0, 0, 4, 90);
    expect_run("const10_shift3", 1, 0, 4, 11);
    expect_run("const10_abs", 2, 0, 4, 90);
    snap(); frame4(0, 255); frame4(0, 20); repeat (6) step();
    expect_cnt("b2b", 0, 8, 2);
    expect_cnt("b2b", 1, 8, 2);
    expect_run("sat255", 0, 0, 4, 255);
    expect_run("sat255_shift3", 1, 0, 4, 255);
    expect_run("const20", 0, 4, 4, 180);
    expect_run("const20_shift3", 1, 4, 4, 22);
    load(sobel);
    snap(); frame4(1, 0); frame4(2, 0); repeat (6) step();
    expect_run("sobel_ramp", 0, 0, 4, 80);
    expect_run("sobel_rev_clamp", 0, 4, 4, 0);
    expect_run("sobel_ramp_abs", 2, 0, 4, 80);
    expect_run("sobel_rev_abs", 2, 4, 4, 80);
    for (int i = 0; i < 11; i++) px(int'($urandom_range(0, 255)), 0);
    snap(); pulse_reset();
    @(negedge clk);
    for (int g = 0; g < 4; g++) chk("coeff_ready_after_reset", g, int'(crdy[g]), 0);
    repeat (5) step();
    chk("flushed_by_reset_count", 0, ccnt[0] - b[0], 0);
    for (int i = 0; i < 9; i++) rc[i] = int'($urandom_range(0, 255));
    load(rc);
    snap();
    for (int i = 0; i < 16; i++) px(int'($urandom_range(0, 255)), 0);
    repeat (6) step();
    expect_cnt("post_reset", 0, 4, 1);
    pulse_reset();
    for (int i = 0; i < 9; i++) rc[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 64; i++) rnd[i] = int'($urandom_range(0, 255));
    load(rc);
    snap();
    for (int i = 0; i < 64; i++) px(rnd[i], 0);
    for (int i = 0; i < 64; i++) px(rnd[i], int'($urandom_range(0, 5)));
    repeat (6) step();
    expect_cnt("rand8x8", 3, 72, 2);
    for (int i = 0; i < 36; i++) chk("gap_vs_nogap", 3, cap_v[3][b[3]+36+i], cap_v[3][b[3]+i]);
    @(negedge clk);
    for (int g = 0; g < 4; g++) chk("pending_outputs", g, wr[g] - rd[g], 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
